// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the DMA copy engine.
//   dma_state_e   : copy engine FSM states
//   HTRANS_*      : transfer-type encodings used by the master
//   HSIZE_WORD, HBURST_SINGLE, HPROT_DATA : fixed attribute values
//   word_align()  : clears the byte-offset bits of an address
package ahb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_DONE = 3'd5
  } dma_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ahb_dma_addr_gen.sv
// Address / count bookkeeping for the DMA copy engine.
//   HCLK, HRESETn   : clock, async active-low reset
//   load            : latch src_in/dst_in (word aligned) and len_in
//   step            : one word finished: src/dst += 4, count -= 1
//   src, dst        : current source / destination byte addresses
//   rem_zero_next   : the count reaches zero when the current word steps
module ahb_dma_addr_gen
  import ahb_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      src_in,
  input  logic [31:0]      dst_in,
  input  logic [LEN_W-1:0] len_in,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic             rem_zero_next
);

  logic [LEN_W-1:0] remaining;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
    end else if (load) begin
      src       <= word_align(src_in);
      dst       <= word_align(dst_in);
      remaining <= len_in;
    end else if (step) begin
      // 32-bit adds wrap naturally past 0xFFFFFFFC.
      src       <= src + 32'd4;
      dst       <= dst + 32'd4;
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign rem_zero_next = (remaining == LEN_W'(1));

endmodule

// File: rtl/ahb_dma_copy.sv
// Single-channel AHB-Lite memory-to-memory word copy engine.
// Each word is a single read (address + data phase) followed by a single
// write; no bursts, no pipelining between transfers.
//   HCLK, HRESETn            : clock, async active-low reset
//   start                    : one-cycle request, accepted only in IDLE
//   src_addr, dst_addr       : byte addresses (low two bits ignored)
//   len_words                : words to copy (0 completes with no bus traffic)
//   busy, done               : in-progress flag, one-cycle completion pulse
//   HADDR..HWDATA            : AHB-Lite master outputs
//   HRDATA, HREADY           : AHB-Lite master inputs
//   irq, irq_clr             : only with AHB_DMA_COPY_IRQ_EN defined; sticky
//                              completion interrupt, irq_clr has priority
// Handshake: an address or data phase completes on a cycle with HREADY=1;
// while HREADY=0 the FSM holds its state, so every bus output stays put.
module ahb_dma_copy
  import ahb_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY
`ifdef AHB_DMA_COPY_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  dma_state_e  state, state_d;
  logic        rst_seen;
  logic        load, step;
  logic [31:0] data_buf;
  logic [31:0] src, dst;
  logic        rem_zero_next;

  ahb_dma_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .load          (load),
    .step          (step),
    .src_in        (src_addr),
    .dst_in        (dst_addr),
    .len_in        (len_words),
    .src           (src),
    .dst           (dst),
    .rem_zero_next (rem_zero_next)
  );

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      ST_IDLE: begin
        // rst_seen blocks a start on the first edge after reset release.
        if (start && rst_seen) begin
          load    = 1'b1;
          state_d = (len_words == '0) ? ST_DONE : ST_RD_A;
        end
      end
      ST_RD_A: if (HREADY) state_d = ST_RD_D;
      ST_RD_D: if (HREADY) state_d = ST_WR_A;
      ST_WR_A: if (HREADY) state_d = ST_WR_D;
      ST_WR_D: begin
        if (HREADY) begin
          step    = 1'b1;
          state_d = rem_zero_next ? ST_DONE : ST_RD_A;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      rst_seen <= 1'b0;
      data_buf <= '0;
    end else begin
      state    <= state_d;
      rst_seen <= 1'b1;
      if (state == ST_RD_D && HREADY) data_buf <= HRDATA;
    end
  end

  // All bus outputs decode from registered state, so they cannot move
  // during a stall and they clear the instant reset asserts.
  assign HTRANS = (state == ST_RD_A || state == ST_WR_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = (state == ST_WR_A || state == ST_WR_D) ? dst : src;
  assign HWRITE = (state == ST_WR_A);
  assign HWDATA = data_buf;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DATA;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

`ifdef AHB_DMA_COPY_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     irq <= 1'b0;
    else if (irq_clr) irq <= 1'b0;
    else if (done)    irq <= 1'b1;
  end
`endif

endmodule
